// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU issue widths, opcode type and packet struct
package alu_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W = 4;
  typedef logic [ALU_OP_W-1:0] alu_op_t;
  typedef struct packed {
    alu_op_t op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_issue_pkt_t;
endpackage

// File: rtl/alu_issue_ram.sv
// alu_issue_ram: DEPTH x W storage, synchronous write, asynchronous read
// Ports: clk, we/waddr/wdata write port, raddr/rdata combinational read port.
module alu_issue_ram import alu_pkg::*; #(
  parameter int W = ALU_OP_W + 2*ALU_DATA_W,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: DEPTH-entry valid/ready FIFO between decode and the ALU
// Ports: clk, resetn (async active-low); in_valid/in_ready/in_op/in_a/in_b upstream;
// out_valid/out_ready/out_op/out_a/out_b to the ALU; flush empties the queue; count = occupancy.
// ALU_ISSUE_BYPASS_EN: when defined, an empty queue forwards a packet the ALU takes at once (latency 0).
module alu_issue_queue import alu_pkg::*; #(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [DATA_W-1:0]          out_a,
  output logic [DATA_W-1:0]          out_b,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W = OP_W + 2*DATA_W;
  logic [AW:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic full, empty, byp, push, pop;
  logic [W-1:0] rdata;
  assign full = (rd_ptr ^ wr_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = rd_ptr == wr_ptr;
`ifdef ALU_ISSUE_BYPASS_EN
  assign byp = empty && !flush && in_valid && out_ready;
`else
  assign byp = 1'b0;
`endif
  assign in_ready = !full && !flush;
  assign out_valid = !empty || byp;
  // a bypassed packet is consumed straight from the input and never stored
  assign push = in_valid && in_ready && !byp;
  assign pop = out_valid && out_ready && !empty;
  assign {out_op, out_a, out_b} = byp ? {in_op, in_a, in_b} : rdata;
  assign wr_n = flush ? '0 : wr_ptr + (AW+1)'(push);
  assign rd_n = flush ? '0 : rd_ptr + (AW+1)'(pop);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count <= CW'(wr_n - rd_n);
    end
  alu_issue_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(push && !flush),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({in_op, in_a, in_b}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for the ALU issue queue (DEPTH=4)
module tb_alu_issue_queue;
  import alu_pkg::*;
  logic clk = 0, resetn = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [3:0] in_op = 0, out_op;
  logic [31:0] in_a = 0, in_b = 0, out_a, out_b;
  logic in_ready, out_valid;
  logic [2:0] count;
  int vectors = 0, errors = 0;
  alu_issue_pkt_t sb[$];
  alu_issue_pkt_t exp_p, got;
  always #5 clk = ~clk;
  assign got = {out_op, out_a, out_b};
  alu_issue_queue #(.DATA_W(32), .OP_W(4), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .flush(flush), .count(count)
  );
  function automatic alu_issue_pkt_t mk(int i);
    alu_issue_pkt_t p;
    p.op = alu_op_t'(i);
    p.a = 32'h1000 + i;
    p.b = 32'h2000 + i * 3;
    return p;
  endfunction
  task automatic set_in(logic v, alu_issue_pkt_t p);
    in_valid = v;
    {in_op, in_a, in_b} = p;
  endtask
  task automatic test_reset;
    resetn = 0;
    set_in(0, '0);
    #1;
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_single;
    alu_issue_pkt_t p;
    p.op = 4'd3; p.a = 32'h10; p.b = 32'h20;
    out_ready = 0;
    set_in(1, p);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    if (in_valid && in_ready) sb.push_back(p);
    @(posedge clk); #1;
    set_in(0, '0);
    @(negedge clk);
    vectors++; if (count !== 3'(sb.size())) begin errors++; $display("FAIL single_count got=%0d exp=%0d", count, sb.size()); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    exp_p = p;
    vectors++; if (got !== exp_p) begin errors++; $display("FAIL single_data got=%h exp=%h", got, exp_p); end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    if (out_valid && sb.size() > 0) begin
      exp_p = sb.pop_front();
      vectors++; if (got !== exp_p) begin errors++; $display("FAIL single_pop got=%h exp=%h", got, exp_p); end
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic test_fill;
    int k;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, mk(i + 16));
      @(negedge clk);
      vectors++; if (in_ready !== (sb.size() < 4)) begin errors++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, sb.size() < 4); end
      if (in_valid && in_ready) sb.push_back(mk(i + 16));
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1;
    k = 0;
    for (int c = 0; c < 20 && (sb.size() > 0 || in_valid); c++) begin
      @(negedge clk);
      vectors++; if (in_ready !== (sb.size() < 4)) begin errors++; $display("FAIL drain_in_ready got=%b exp=%b", in_ready, sb.size() < 4); end
      vectors++; if (out_valid !== (sb.size() > 0)) begin errors++; $display("FAIL drain_out_valid got=%b exp=%b", out_valid, sb.size() > 0); end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_p = sb.pop_front();
        vectors++; if (got !== exp_p) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, got, exp_p); end
        k++;
      end
      if (in_valid && in_ready) sb.push_back(mk(20));
      @(posedge clk); #1;
      if (in_valid && sb.size() > 0 && sb[sb.size()-1] == mk(20)) set_in(0, '0);
    end
    vectors++; if (k !== 5 || sb.size() != 0) begin errors++; $display("FAIL fill_drain_total got=%0d exp=5 left=%0d", k, sb.size()); end
    out_ready = 0;
  endtask
  task automatic test_stream;
    int outs;
    outs = 0;
    out_ready = 1;
    for (int c = 0; c < 17; c++) begin
      set_in(c < 16, mk(c + 100));
      @(negedge clk);
      vectors++; if (count > 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp<=1", c, count); end
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", c, in_ready); end
      vectors++; if (out_valid !== (sb.size() > 0)) begin errors++; $display("FAIL stream_out_valid[%0d] got=%b exp=%b", c, out_valid, sb.size() > 0); end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_p = sb.pop_front();
        vectors++; if (got !== exp_p) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", c, got, exp_p); end
        outs++;
      end
      if (in_valid && in_ready) sb.push_back(mk(c + 100));
      @(posedge clk); #1;
    end
    set_in(0, '0);
    @(negedge clk);
    vectors++; if (outs !== 16 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_total got=%0d valid=%b exp=16 valid=0", outs, out_valid); end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic test_flush;
    alu_issue_pkt_t bad;
    bad.op = 4'hF; bad.a = 32'hDEAD; bad.b = 32'hBEEF;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, mk(i + 40));
      @(posedge clk); #1;
      sb.push_back(mk(i + 40));
    end
    set_in(1, bad);
    out_ready = 1;
    flush = 1;
    @(negedge clk);
    vectors++; if (count !== 3'd3) begin errors++; $display("FAIL flush_precount got=%0d exp=3", count); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    sb.delete();
    flush = 0;
    set_in(0, '0);
    out_ready = 0;
    @(negedge clk);
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    set_in(1, mk(50));
    @(posedge clk); #1;
    sb.push_back(mk(50));
    set_in(0, '0);
    out_ready = 1;
    @(negedge clk);
    exp_p = sb.pop_front();
    vectors++; if (out_valid !== 1'b1 || got !== exp_p) begin errors++; $display("FAIL flush_after got=%b/%h exp=1/%h", out_valid, got, exp_p); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got=%b/%h exp=0", out_valid, got); end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic test_async_reset;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_in(1, mk(i + 60));
      @(posedge clk); #1;
    end
    set_in(0, '0);
    @(negedge clk);
    vectors++; if (count !== 3'd2) begin errors++; $display("FAIL areset_precount got=%0d exp=2", count); end
    #2 resetn = 0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    resetn = 1;
    sb.delete();
    set_in(1, mk(70));
    @(posedge clk); #1;
    sb.push_back(mk(70));
    set_in(0, '0);
    vectors++; if (count !== 3'd1) begin errors++; $display("FAIL areset_first_push got=%0d exp=1", count); end
    out_ready = 1;
    @(negedge clk);
    exp_p = sb.pop_front();
    vectors++; if (got !== exp_p) begin errors++; $display("FAIL areset_data got=%h exp=%h", got, exp_p); end
    @(posedge clk); #1;
    out_ready = 0;
  endtask
`ifdef ALU_ISSUE_BYPASS_EN
  task automatic test_bypass;
    alu_issue_pkt_t p;
    p.op = 4'd5; p.a = 32'hAB; p.b = 32'hCD;
    set_in(1, p);
    out_ready = 1;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_a !== 32'hAB) begin errors++; $display("FAIL bypass_out got=%b/%h exp=1/ab", out_valid, out_a); end
    @(posedge clk); #1;
    set_in(0, '0);
    out_ready = 0;
    vectors++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count got=%0d exp=0", count); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_async_reset();
`ifdef ALU_ISSUE_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
